// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: FSM encoding,
// divide length and small two's-complement helpers.
package mul_div_unit_pkg;

    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = $clog2(DIV_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Magnitude of a 32-bit operand; only negative values of signed ops flip.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

    // Conditional two's-complement negation used by the divide sign fix-up.
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// EXE-stage <-> multiply/divide unit signal bundle.
// Handshake: multiply/div are requests held by the EXE stage; the unit answers
// with stall. A request is consumed on a rising edge where stall is 0 (multiply)
// or where the unit leaves DONE (divide). flush kills the request in flight.
interface mul_div_unit_if;
    logic        multiply;
    logic        div;
    logic        unsign;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output multiply, div, unsign, src1, src2, flush, hi_we, lo_we, wdata,
        input  stall, hi, lo
    );

    modport slave (
        input  multiply, div, unsign, src1, src2, flush, hi_we, lo_we, wdata,
        output stall, hi, lo
    );
endinterface

// File: rtl/mul_div_unit_div_core.sv
// Restoring divider datapath: operand magnitudes, partial remainder, one
// shift/subtract step per cycle and the step counter. Sign fix-up of the
// final result is left to the caller, which gets the sign flags.
module div_core
    import mul_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        step,
    input  logic        unsign,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [31:0] quo_next,
    output logic [31:0] rem_next,
    output logic        neg_quo,
    output logic        neg_rem,
    output logic        last
);

    // quo_q starts as the dividend magnitude; its top bit shifts into the
    // remainder each step while the new quotient bit enters at the bottom.
    logic [31:0]      quo_q;
    logic [31:0]      rem_q;
    logic [31:0]      dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_quo_q;
    logic             neg_rem_q;

    logic [32:0]      partial;
    logic             fits;

    // One restoring step. A zero divisor always fits, which yields an
    // all-ones quotient and leaves the dividend in the remainder.
    always_comb begin
        partial  = {rem_q, quo_q[31]};
        fits     = (partial >= {1'b0, dvs_q});
        rem_next = fits ? (partial[31:0] - dvs_q) : partial[31:0];
        quo_next = {quo_q[30:0], fits};
    end

    // Operand capture on start, then one step per enabled cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (start) begin
            quo_q     <= abs32(src1, !unsign);
            rem_q     <= '0;
            dvs_q     <= abs32(src2, !unsign);
            cnt_q     <= '0;
            neg_quo_q <= !unsign && (src1[31] ^ src2[31]);
            neg_rem_q <= !unsign && src1[31];
        end else if (step) begin
            quo_q <= quo_next;
            rem_q <= rem_next;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign neg_quo = neg_quo_q;
    assign neg_rem = neg_rem_q;
    assign last    = (cnt_q == CNT_W'(DIV_CYCLES - 1));

endmodule

// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit: single-cycle multiply, 32-step iterative
// divide, MTHI/MTLO writes and the EXE-stage stall.
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic           clk,
    input  logic           resetn,
    mul_div_unit_if.slave  bus,
    output state_e         dbg_state
);

    state_e      state_q;
    state_e      state_d;

    logic        div_start;
    logic        div_step;
    logic        div_finish;
    logic        mul_fire;
    logic        stall;

    logic [31:0] quo_next;
    logic [31:0] rem_next;
    logic        neg_quo;
    logic        neg_rem;
    logic        last;

    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [63:0] product;

    logic [31:0] hi_q;
    logic [31:0] lo_q;

    div_core u_div_core (
        .clk      (clk),
        .resetn   (resetn),
        .start    (div_start),
        .step     (div_step),
        .unsign   (bus.unsign),
        .src1     (bus.src1),
        .src2     (bus.src2),
        .quo_next (quo_next),
        .rem_next (rem_next),
        .neg_quo  (neg_quo),
        .neg_rem  (neg_rem),
        .last     (last)
    );

    // Next-state and control decode; div beats multiply if both are raised.
    always_comb begin
        state_d    = state_q;
        div_start  = 1'b0;
        div_step   = 1'b0;
        div_finish = 1'b0;
        mul_fire   = 1'b0;
        stall      = 1'b0;
        case (state_q)
            IDLE: begin
                div_start = bus.div && !bus.flush;
                mul_fire  = bus.multiply && !bus.div && !bus.flush;
                stall     = div_start;
                if (div_start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                div_step   = !bus.flush;
                div_finish = div_step && last;
                stall      = !bus.flush;
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // 64-bit product; sign-extending to 64 bits makes a plain multiply
    // produce the correct signed or unsigned low 64 bits.
    always_comb begin
        op_a    = {{32{bus.src1[31] & !bus.unsign}}, bus.src1};
        op_b    = {{32{bus.src2[31] & !bus.unsign}}, bus.src2};
        product = op_a * op_b;
    end

    // HI/LO registers: unit results take precedence over MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (mul_fire) begin
            hi_q <= product[63:32];
            lo_q <= product[31:0];
        end else if (div_finish) begin
            hi_q <= neg_if(rem_next, neg_rem);
            lo_q <= neg_if(quo_next, neg_quo);
        end else begin
            if (bus.hi_we) begin
                hi_q <= bus.wdata;
            end
            if (bus.lo_we) begin
                lo_q <= bus.wdata;
            end
        end
    end

    assign bus.stall = stall;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with a scoreboard: drivers push expected
// {hi,lo} pairs, a monitor pops and compares on DONE or on an observe strobe.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    // Clock and reset
    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mul_div_unit_if bus();
    state_e dbg_state;

    mul_div_unit dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Scoreboard
    logic [63:0] exp_q[$];
    string       tag_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        chk_strobe = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
        exp_q.push_back({ehi, elo});
        tag_q.push_back(tag);
    endtask

    // Monitor: a divide result is presented in DONE; other results are
    // presented when a driver raises the observe strobe.
    always @(negedge clk) begin
        if (resetn && (dbg_state == DONE || chk_strobe)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_result: got %h expected none", {bus.hi, bus.lo});
            end else begin
                check(tag_q.pop_front(), {bus.hi, bus.lo}, exp_q.pop_front());
            end
        end
    end

    // Driver tasks
    task automatic idle_inputs();
        bus.multiply = 1'b0;
        bus.div      = 1'b0;
        bus.unsign   = 1'b0;
        bus.src1     = '0;
        bus.src2     = '0;
        bus.flush    = 1'b0;
        bus.hi_we    = 1'b0;
        bus.lo_we    = 1'b0;
        bus.wdata    = '0;
    endtask

    // Call #1 after a rising edge: compares {hi,lo} at the coming negedge.
    task automatic observe(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
        expect_hilo(tag, ehi, elo);
        chk_strobe = 1'b1;
        @(negedge clk);
        #1 chk_strobe = 1'b0;
    endtask

    task automatic do_mul(input string tag, input logic uns, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        @(posedge clk); #1;
        bus.multiply = 1'b1;
        bus.unsign   = uns;
        bus.src1     = a;
        bus.src2     = b;
        @(negedge clk);
        check({tag, "_stall"}, 64'(bus.stall), 64'd0);
        @(posedge clk); #1;
        bus.multiply = 1'b0;
        observe(tag, ehi, elo);
    endtask

    task automatic do_div(input string tag, input logic uns, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic also_mul, input logic mt_collide);
        int cnt;
        @(posedge clk); #1;
        bus.div      = 1'b1;
        bus.multiply = also_mul;
        bus.unsign   = uns;
        bus.src1     = a;
        bus.src2     = b;
        expect_hilo(tag, ehi, elo);
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!bus.stall) break;
            cnt++;
            if (cnt == 4) begin
                bus.src1 = ~a;
                bus.src2 = a ^ b ^ 32'h5a5a_0f0f;
            end
            if (mt_collide && cnt == 33) begin
                bus.hi_we = 1'b1;
                bus.wdata = 32'haaaa_0000;
            end
            if (cnt > 100) begin
                $display("FAIL %s_timeout: got stall stuck after %0d cycles expected release", tag, cnt);
                break;
            end
        end
        bus.hi_we = 1'b0;
        check({tag, "_stall_cycles"}, 64'(cnt), 64'd33);
        @(posedge clk); #1;
        bus.div      = 1'b0;
        bus.multiply = 1'b0;
    endtask

    // Stimulus
    initial begin
        idle_inputs();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        observe("reset_hilo", 32'h0, 32'h0);
        check("reset_state", 64'(dbg_state), 64'(IDLE));
        check("reset_stall", 64'(bus.stall), 64'd0);

        do_mul("mult_signed",   1'b0, 32'hffff_fffe, 32'd3, 32'hffff_ffff, 32'hffff_fffa);
        do_mul("multu",         1'b1, 32'hffff_fffe, 32'd3, 32'h0000_0002, 32'hffff_fffa);
        do_mul("mult_pow2",     1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);

        do_div("div_neg7_2",    1'b0, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 32'hffff_fffd, 1'b0, 1'b0);
        do_div("divu_100_7",    1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
        do_div("divu_5_0",      1'b1, 32'd5, 32'd0, 32'd5, 32'hffff_ffff, 1'b0, 1'b0);
        do_div("div_neg5_0",    1'b0, 32'hffff_fffb, 32'd0, 32'hffff_fffb, 32'h0000_0001, 1'b0, 1'b0);
        do_div("div_7_neg2",    1'b0, 32'd7, 32'hffff_fffe, 32'h0000_0001, 32'hffff_fffd, 1'b0, 1'b0);
        do_div("div_min_neg1",  1'b0, 32'h8000_0000, 32'hffff_ffff, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
        do_div("div_and_mul",   1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, 1'b0);

        // MTHI on the result edge loses; hi holds the remainder afterwards.
        do_div("div_mthi_collide", 1'b1, 32'd45, 32'd6, 32'd3, 32'd7, 1'b0, 1'b1);
        observe("after_collide", 32'd3, 32'd7);

        // MTLO then MTHI in IDLE.
        @(posedge clk); #1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hcafe_babe;
        @(posedge clk); #1;
        bus.lo_we = 1'b0;
        observe("mtlo_idle", 32'd3, 32'hcafe_babe);
        @(posedge clk); #1;
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0bad_f00d;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        observe("mthi_idle", 32'h0bad_f00d, 32'hcafe_babe);

        // Flush in IDLE suppresses both multiply and divide start.
        @(posedge clk); #1;
        bus.multiply = 1'b1;
        bus.flush    = 1'b1;
        bus.src1     = 32'd9;
        bus.src2     = 32'd9;
        @(posedge clk); #1;
        bus.multiply = 1'b0;
        bus.div      = 1'b1;
        observe("flush_idle_mul", 32'h0bad_f00d, 32'hcafe_babe);
        check("flush_idle_div_stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #1;
        bus.div   = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_idle_div_state", 64'(dbg_state), 64'(IDLE));

        // Flush at RUN cycle 10 with hi=lo=0x12345678 preset.
        @(posedge clk); #1;
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h1234_5678;
        @(posedge clk); #1;
        bus.hi_we  = 1'b0;
        bus.lo_we  = 1'b0;
        bus.div    = 1'b1;
        bus.unsign = 1'b1;
        bus.src1   = 32'd100;
        bus.src2   = 32'd7;
        repeat (10) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(negedge clk);
        check("flush_run_stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.div   = 1'b0;
        observe("flush_run_hold", 32'h1234_5678, 32'h1234_5678);
        check("flush_run_state", 64'(dbg_state), 64'(IDLE));
        check("flush_run_stall_after", 64'(bus.stall), 64'd0);
        do_div("div_after_flush", 1'b0, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 32'hffff_fffd, 1'b0, 1'b0);

        // Reset at RUN cycle 5 abandons the divide.
        @(posedge clk); #1;
        bus.div    = 1'b1;
        bus.unsign = 1'b1;
        bus.src1   = 32'd100;
        bus.src2   = 32'd7;
        repeat (5) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk); #1;
        resetn  = 1'b1;
        bus.div = 1'b0;
        observe("reset_mid_run", 32'h0, 32'h0);
        check("reset_mid_run_state", 64'(dbg_state), 64'(IDLE));
        check("reset_mid_run_stall", 64'(bus.stall), 64'd0);

        do_mul("mult_after_reset", 1'b0, 32'hffff_fffe, 32'hffff_fffe, 32'h0, 32'd4);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL pending_results: got %0d outstanding expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
